// File: rtl/vga_timing_pkg.sv
// Purpose : shared constants and helpers for the VGA raster timing generator.
// Latency : n/a (package only).
// Backpressure: n/a.
//
// Contents: default 640x480@60 raster geometry, the coordinate width and the
// line/frame total helpers used by the counter and top level.
package vga_timing_pkg;

  // Coordinate width; both totals must fit in this many bits (<= 4096).
  localparam int unsigned COORD_W = 12;

  // 640x480 @ 60 Hz, 800 x 525 total.
  localparam int unsigned DEF_HSIZE = 640;
  localparam int unsigned DEF_HFP   = 16;
  localparam int unsigned DEF_HSW   = 96;
  localparam int unsigned DEF_HBP   = 48;
  localparam int unsigned DEF_VSIZE = 480;
  localparam int unsigned DEF_VFP   = 10;
  localparam int unsigned DEF_VSW   = 2;
  localparam int unsigned DEF_VBP   = 33;

  function automatic int unsigned htotal(input int unsigned size, input int unsigned fp,
                                         input int unsigned sw, input int unsigned bp);
    return size + fp + sw + bp;
  endfunction

  function automatic int unsigned vtotal(input int unsigned size, input int unsigned fp,
                                         input int unsigned sw, input int unsigned bp);
    return size + fp + sw + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Purpose : one raster dimension -- wrapping counter plus active/sync decode.
// Latency : count is registered; active/sync_n/wrap are combinational from it.
// Backpressure: none; en_i low holds the count.
//
// Ports: clk_i/rst_i (sync, active-high), en_i advance enable,
//        count_o current position, active_o inside visible area,
//        sync_n_o active-low sync, wrap_o count is at its last value.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned SIZE = DEF_HSIZE,
  parameter int unsigned FP   = DEF_HFP,
  parameter int unsigned SW   = DEF_HSW,
  parameter int unsigned BP   = DEF_HBP
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  output logic [COORD_W-1:0] count_o,
  output logic               active_o,
  output logic               sync_n_o,
  output logic               wrap_o
);

  localparam int unsigned TOTAL = htotal(SIZE, FP, SW, BP);
  // One extra bit so a boundary equal to 4096 still compares correctly.
  localparam int unsigned XW = COORD_W + 1;
  localparam logic [XW-1:0] LAST     = XW'(TOTAL - 1);
  localparam logic [XW-1:0] ACT_END  = XW'(SIZE);
  localparam logic [XW-1:0] SYNC_BEG = XW'(SIZE + FP);
  localparam logic [XW-1:0] SYNC_END = XW'(SIZE + FP + SW);

  logic [COORD_W-1:0] count_q, count_d;
  logic [XW-1:0]      count_x;

  assign count_x  = {1'b0, count_q};
  assign wrap_o   = (count_x == LAST);
  assign active_o = (count_x < ACT_END);
  assign sync_n_o = !((count_x >= SYNC_BEG) && (count_x < SYNC_END));
  assign count_o  = count_q;

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = wrap_o ? '0 : count_q + COORD_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose : VGA raster timing generator (syncs, DE, coordinates, strobes).
// Latency : 1 clock from internal counter value to every output; no comb in->out path.
// Backpressure: none; CE low freezes counters and all outputs (strobes stretch).
//
// Ports: CLK pixel clock, RESET sync active-high (beats CE), CE clock enable,
//        Hsync/Vsync active-low syncs, DE active area, hpos/vpos coordinates of
//        the pixel the other outputs describe, line_start/frame_start strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned HSIZE = DEF_HSIZE,
  parameter int unsigned HFP   = DEF_HFP,
  parameter int unsigned HSW   = DEF_HSW,
  parameter int unsigned HBP   = DEF_HBP,
  parameter int unsigned VSIZE = DEF_VSIZE,
  parameter int unsigned VFP   = DEF_VFP,
  parameter int unsigned VSW   = DEF_VSW,
  parameter int unsigned VBP   = DEF_VBP
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               CE,
  output logic               Hsync,
  output logic               Vsync,
  output logic               DE,
  output logic [COORD_W-1:0] hpos,
  output logic [COORD_W-1:0] vpos,
  output logic               line_start,
  output logic               frame_start
);

  logic [COORD_W-1:0] h_cnt, v_cnt;
  logic               h_act, h_sync_n, h_wrap;
  logic               v_act, v_sync_n, v_wrap;
  logic               v_en;

  // Vertical advances only on the clock where the line wraps.
  assign v_en = CE && h_wrap;

  vga_axis_counter #(.SIZE(HSIZE), .FP(HFP), .SW(HSW), .BP(HBP)) u_h (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .en_i    (CE),
    .count_o (h_cnt),
    .active_o(h_act),
    .sync_n_o(h_sync_n),
    .wrap_o  (h_wrap)
  );

  vga_axis_counter #(.SIZE(VSIZE), .FP(VFP), .SW(VSW), .BP(VBP)) u_v (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .en_i    (v_en),
    .count_o (v_cnt),
    .active_o(v_act),
    .sync_n_o(v_sync_n),
    .wrap_o  (v_wrap)
  );

  logic               hsync_q, vsync_q, de_q, ls_q, fs_q;
  logic               hsync_d, vsync_d, de_d, ls_d, fs_d;
  logic [COORD_W-1:0] hpos_q, vpos_q;

  always_comb begin
    hsync_d = h_sync_n;
    vsync_d = v_sync_n;
    de_d    = h_act && v_act;
    ls_d    = (h_cnt == '0);
    fs_d    = (h_cnt == '0) && (v_cnt == '0);
  end

  // Output stage registers the decode of the pre-edge counter value, so the
  // coordinates and every sync/strobe describe the same pixel.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      hpos_q  <= '0;
      vpos_q  <= '0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else if (CE) begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      hpos_q  <= h_cnt;
      vpos_q  <= v_cnt;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  assign Hsync       = hsync_q;
  assign Vsync       = vsync_q;
  assign DE          = de_q;
  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

  // Last pixel of the frame: both counters must land on zero together.
  a_frame_wrap: assert property (@(posedge CLK) disable iff (RESET)
    (CE && h_wrap && v_wrap) |=> (h_cnt == '0 && v_cnt == '0));

endmodule
